// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle control FSM:
// states, opcodes, mux selects and small decode helpers.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECUTE  = 4'd2,
        S_ALUWB    = 4'd3,
        S_MEMADR   = 4'd4,
        S_MEMREAD  = 4'd5,
        S_MEMWB    = 4'd6,
        S_MEMWRITE = 4'd7,
        S_BRANCH   = 4'd8,
        S_FAULT    = 4'd9
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_CMP = 3'b011;
    localparam logic [2:0] OP_LDR = 3'b100;
    localparam logic [2:0] OP_STR = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_B   = 3'b111;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REG  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic is_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts consecutive memory wait cycles; flags the cycle that
// would be the TIMEOUT-th consecutive low MemReady cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // cnt_q holds earlier low cycles, so this one makes TIMEOUT
    assign timeout = en && (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM sequencing the shared ALU, register file
// and unified memory, with zero flag and memory wait timeout.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] InstrCode,
    input  logic       ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUControl,
    output logic       ZFlag,
    output logic       Fault
);

    state_e state_q;
    state_e state_d;
    logic   zflag_q;
    logic   zflag_d;
    logic   wait_en;
    logic   wait_clr;
    logic   timeout;

    assign wait_en  = is_wait(state_q) && !MemReady;
    assign wait_clr = (state_d != state_q);

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .en     (wait_en),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        zflag_d = zflag_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady)     state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (InstrCode)
                    OP_LDR, OP_STR: state_d = S_MEMADR;
                    OP_BEQ, OP_B:   state_d = S_BRANCH;
                    default:        state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                if (is_sub(InstrCode)) zflag_d = ALUFlags;
                state_d = (InstrCode == OP_CMP) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: state_d = S_FETCH;
            S_MEMADR: begin
                state_d = (InstrCode == OP_STR) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (MemReady)     state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWRITE: begin
                if (MemReady)     state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_BRANCH: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        Fault      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_EXECUTE: begin
                ALUSrcA    = SRCA_REG;
                ALUControl = is_sub(InstrCode) ? ALU_SUB : ALU_ADD;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_MEM;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = (InstrCode == OP_B) ||
                            ((InstrCode == OP_BEQ) && zflag_q);
            end
            S_FAULT:  Fault = 1'b1;
            default:  ;
        endcase
        // Strobes must be quiet for the whole reset pulse, not just after the edge
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_REG;
            ResultSrc  = RES_ALUOUT;
            ALUControl = ALU_ADD;
            Fault      = 1'b0;
        end
    end

    assign ZFlag = zflag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zflag_q <= zflag_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] InstrCode = 3'b000;
    logic       ALUFlags = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, IRWrite, MemRead, MemWrite, AdrSrc, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic       ALUControl, ZFlag, Fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [14:0] vec;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .InstrCode (InstrCode),
        .ALUFlags  (ALUFlags),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUControl(ALUControl),
        .ZFlag     (ZFlag),
        .Fault     (Fault)
    );

    logic [14:0] act;
    assign act = {PCWrite, IRWrite, MemRead, MemWrite, AdrSrc, RegWrite,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ZFlag, Fault};

    function automatic logic [14:0] mk(
        input logic pcw, input logic irw, input logic mr, input logic mw,
        input logic adr, input logic rw, input logic [1:0] sa,
        input logic [1:0] sb, input logic [1:0] rs, input logic ac,
        input logic z, input logic f);
        return {pcw, irw, mr, mw, adr, rw, sa, sb, rs, ac, z, f};
    endfunction

    function automatic logic [14:0] e_f(input logic rdy, input logic z);
        return mk(rdy, rdy, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_d(input logic z);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_ex(input logic ac, input logic z);
        return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ac, z, 0);
    endfunction
    function automatic logic [14:0] e_wb(input logic z);
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_ma(input logic z);
        return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_mr(input logic z);
        return mk(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_mwb(input logic z);
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_mw(input logic z);
        return mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_br(input logic p, input logic z);
        return mk(p, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, z, 0);
    endfunction
    function automatic logic [14:0] e_flt(input logic z);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, z, 1);
    endfunction

    localparam logic [14:0] E_RST = 15'd0;

    task automatic cyc(input logic rdy, input logic [2:0] ic,
                       input logic fl, input logic [14:0] e,
                       input string nm);
        exp_t x;
        MemReady  = rdy;
        InstrCode = ic;
        ALUFlags  = fl;
        x.vec  = e;
        x.name = nm;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (act !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.vec);
                end
            end
        end
    end

    initial begin : stim
        @(posedge clk);
        #1;
        // reset held three cycles
        for (int i = 0; i < 3; i++) cyc(1, 3'b000, 0, E_RST, "reset");
        reset = 1'b0;

        // ADD
        cyc(1, 3'b000, 0, e_f(1, 0), "add_fetch");
        cyc(1, 3'b000, 0, e_d(0), "add_decode");
        cyc(1, 3'b000, 0, e_ex(0, 0), "add_exec");
        cyc(1, 3'b000, 0, e_wb(0), "add_wb");

        // CMP equal then BEQ taken
        cyc(1, 3'b011, 1, e_f(1, 0), "cmp1_fetch");
        cyc(1, 3'b011, 1, e_d(0), "cmp1_decode");
        cyc(1, 3'b011, 1, e_ex(1, 0), "cmp1_exec");
        cyc(1, 3'b110, 0, e_f(1, 1), "beq1_fetch");
        cyc(1, 3'b110, 0, e_d(1), "beq1_decode");
        cyc(1, 3'b110, 0, e_br(1, 1), "beq1_branch");

        // CMP not equal then BEQ not taken, B always taken
        cyc(1, 3'b011, 0, e_f(1, 1), "cmp0_fetch");
        cyc(1, 3'b011, 0, e_d(1), "cmp0_decode");
        cyc(1, 3'b011, 0, e_ex(1, 1), "cmp0_exec");
        cyc(1, 3'b110, 1, e_f(1, 0), "beq0_fetch");
        cyc(1, 3'b110, 1, e_d(0), "beq0_decode");
        cyc(1, 3'b110, 1, e_br(0, 0), "beq0_branch");
        cyc(1, 3'b111, 0, e_f(1, 0), "b_fetch");
        cyc(1, 3'b111, 0, e_d(0), "b_decode");
        cyc(1, 3'b111, 0, e_br(1, 0), "b_branch");

        // LDR with three wait cycles in MEMREAD
        cyc(1, 3'b100, 0, e_f(1, 0), "ldr_fetch");
        cyc(1, 3'b100, 0, e_d(0), "ldr_decode");
        cyc(1, 3'b100, 0, e_ma(0), "ldr_memadr");
        for (int i = 0; i < 3; i++) cyc(0, 3'b100, 0, e_mr(0), "ldr_wait");
        cyc(1, 3'b100, 0, e_mr(0), "ldr_read_done");
        cyc(1, 3'b100, 0, e_mwb(0), "ldr_memwb");

        // ready arriving in the timeout cycle completes the fetch
        for (int i = 0; i < 3; i++) cyc(0, 3'b001, 0, e_f(0, 0), "sub_fetch_wait");
        cyc(1, 3'b001, 0, e_f(1, 0), "sub_fetch_late");
        cyc(1, 3'b001, 0, e_d(0), "sub_decode");
        cyc(1, 3'b001, 0, e_ex(1, 0), "sub_exec");
        cyc(1, 3'b001, 0, e_wb(0), "sub_wb");

        // set Z, then MOV and ADD must leave it alone
        cyc(1, 3'b011, 1, e_f(1, 0), "cmpz_fetch");
        cyc(1, 3'b011, 1, e_d(0), "cmpz_decode");
        cyc(1, 3'b011, 1, e_ex(1, 0), "cmpz_exec");
        cyc(1, 3'b010, 0, e_f(1, 1), "mov_fetch");
        cyc(1, 3'b010, 0, e_d(1), "mov_decode");
        cyc(1, 3'b010, 0, e_ex(0, 1), "mov_exec");
        cyc(1, 3'b010, 0, e_wb(1), "mov_wb");
        cyc(1, 3'b000, 0, e_f(1, 1), "add2_fetch");
        cyc(1, 3'b000, 0, e_d(1), "add2_decode");
        cyc(1, 3'b000, 0, e_ex(0, 1), "add2_exec");
        cyc(1, 3'b000, 0, e_wb(1), "add2_wb");

        // STR aborted by reset while in MEMWRITE
        cyc(1, 3'b101, 0, e_f(1, 1), "str_fetch");
        cyc(1, 3'b101, 0, e_d(1), "str_decode");
        cyc(1, 3'b101, 0, e_ma(1), "str_memadr");
        begin
            exp_t x;
            MemReady = 1'b0;
            x.vec  = e_mw(1);
            x.name = "str_memwrite";
            sb_q.push_back(x);
        end
        #6;
        reset = 1'b1;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0 || ZFlag !== 1'b0) begin
            n_fail++;
            $display("FAIL str_reset_abort: MemWrite=%b ZFlag=%b required 0 0",
                     MemWrite, ZFlag);
        end
        @(posedge clk);
        #1;
        cyc(0, 3'b101, 0, E_RST, "str_reset_hold");
        reset = 1'b0;
        cyc(1, 3'b000, 0, e_f(1, 0), "post_reset_fetch");
        cyc(1, 3'b000, 0, e_d(0), "post_reset_decode");
        cyc(1, 3'b000, 0, e_ex(0, 0), "post_reset_exec");
        cyc(1, 3'b000, 0, e_wb(0), "post_reset_wb");

        // fetch timeout: four low cycles, then absorbing FAULT
        for (int i = 0; i < 4; i++) cyc(0, 3'b000, 0, e_f(0, 0), "to_fetch_wait");
        for (int i = 0; i < 3; i++) cyc(1, 3'b111, 0, e_flt(0), "fault_hold");
        reset = 1'b1;
        cyc(1, 3'b111, 0, E_RST, "fault_reset");
        reset = 1'b0;
        cyc(1, 3'b111, 0, e_f(1, 0), "recover_fetch");
        cyc(1, 3'b111, 0, e_d(0), "recover_decode");
        cyc(1, 3'b111, 0, e_br(1, 0), "recover_branch");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
